// File: rtl/master_port.sv
// Serial bus master: shifts a 13-bit request (address, write byte, burst word)
// out LSB first, then collects one or more read bytes, with split-response support.
module master_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [11:0] addr_in,
  input  logic [7:0]  wdata_in,
  input  logic        burst_in,
  input  logic [11:0] burst_len_in,
  input  logic        slave_ready,
  input  logic        slave_valid,
  input  logic        split_en,
  input  logic        rx_data,
  output logic        master_valid,
  output logic        master_ready,
  output logic        read_en,
  output logic        write_en,
  output logic        tx_address,
  output logic        tx_data,
  output logic        tx_burst,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, REQ, RWAIT, SPLIT, RX, DONE} state_t;

  state_t      state, next_state;
  logic        rw_q;
  logic        burst_q;
  logic [11:0] len_q;
  logic [11:0] addr_sh;
  logic [7:0]  wdata_sh;
  logic [12:0] burst_sh;
  logic [3:0]  k;
  logic [2:0]  j;
  logic [6:0]  rx_sh;
  logic [11:0] beat_cnt;
  logic [11:0] beat_target;
  logic        accept;
  logic        cap;
  logic        byte_done;
  logic        launch;

  // A zero burst length still means one beat.
  assign beat_target = (burst_q && (len_q != 12'd0)) ? len_q : 12'd1;
  assign byte_done   = cap && (j == 3'd7);
  assign launch      = (state == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    master_valid = 1'b0;
    master_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    cap          = 1'b0;
    case (state)
      IDLE: if (start) next_state = REQ;
      REQ: begin
        master_valid = 1'b1;
        busy         = 1'b1;
        if (slave_ready) begin
          accept = 1'b1;
          if (k == 4'd12) next_state = rw_q ? DONE : RWAIT;
        end
      end
      RWAIT: begin
        master_ready = 1'b1;
        busy         = 1'b1;
        if (split_en) next_state = SPLIT;
        else if (slave_valid) begin
          cap        = 1'b1;
          next_state = RX;
        end
      end
      SPLIT: begin
        busy = 1'b1;
        if (slave_valid) begin
          cap        = 1'b1;
          next_state = RX;
        end
      end
      RX: begin
        master_ready = 1'b1;
        busy         = 1'b1;
        if (slave_valid) begin
          cap = 1'b1;
          if ((j == 3'd7) && ((beat_cnt + 12'd1) == beat_target)) next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign read_en    = busy && !rw_q;
  assign write_en   = busy && rw_q;
  assign tx_address = master_valid && addr_sh[0];
  assign tx_data    = master_valid && wdata_sh[0];
  assign tx_burst   = master_valid && burst_sh[0];

  // Request shifters, receive shifter and beat counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q        <= 1'b0;
      burst_q     <= 1'b0;
      len_q       <= 12'd0;
      addr_sh     <= 12'd0;
      wdata_sh    <= 8'd0;
      burst_sh    <= 13'd0;
      k           <= 4'd0;
      j           <= 3'd0;
      rx_sh       <= 7'd0;
      beat_cnt    <= 12'd0;
      rdata       <= 8'd0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= byte_done;
      if (launch) begin
        rw_q     <= rw;
        burst_q  <= burst_in & ~rw;
        len_q    <= burst_len_in;
        addr_sh  <= addr_in;
        wdata_sh <= rw ? wdata_in : 8'd0;
        burst_sh <= {burst_len_in, burst_in & ~rw};
        k        <= 4'd0;
        j        <= 3'd0;
        beat_cnt <= 12'd0;
      end
      if (accept) begin
        addr_sh  <= addr_sh >> 1;
        wdata_sh <= wdata_sh >> 1;
        burst_sh <= burst_sh >> 1;
        k        <= k + 4'd1;
      end
      if (cap) begin
        rx_sh <= {rx_data, rx_sh[6:1]};
        j     <= j + 3'd1;
      end
      if (byte_done) begin
        rdata    <= {rx_data, rx_sh};
        beat_cnt <= beat_cnt + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write, stalled write, single/split/burst
// reads and a mid-transfer reset, each with hand-computed expectations.
module tb_master_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, rw = 1'b0, burst_in = 1'b0;
  logic [11:0] addr_in = 12'd0, burst_len_in = 12'd0;
  logic [7:0]  wdata_in = 8'd0;
  logic        slave_ready = 1'b1, slave_valid = 1'b0, split_en = 1'b0, rx_data = 1'b0;
  logic        master_valid, master_ready, read_en, write_en;
  logic        tx_address, tx_data, tx_burst, rdata_valid, busy, done;
  logic [7:0]  rdata;

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0;
  int done_cnt = 0;
  logic [7:0] rv_q[$];

  wire [17:0] all_out = {master_valid, master_ready, read_en, write_en, tx_address,
                         tx_data, tx_burst, rdata, rdata_valid, busy, done};

  master_port dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr_in(addr_in),
    .wdata_in(wdata_in), .burst_in(burst_in), .burst_len_in(burst_len_in),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .split_en(split_en),
    .rx_data(rx_data), .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en), .tx_address(tx_address),
    .tx_data(tx_data), .tx_burst(tx_burst), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      rv_cnt++;
      rv_q.push_back(rdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_start(input logic w, input logic [11:0] a, input logic [7:0] d,
                          input logic b, input logic [11:0] n);
    @(negedge clk);
    start = 1'b1; rw = w; addr_in = a; wdata_in = d; burst_in = b; burst_len_in = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect_req(input int stall_k, input int stall_n,
                             output logic [12:0] ab, output logic [12:0] db,
                             output logic [12:0] bb, output int vc, output logic hold_ok);
    int kb;
    int left;
    logic [2:0] held;
    ab = '0; db = '0; bb = '0; vc = 0; kb = 0; left = stall_n; hold_ok = 1'b1; held = '0;
    for (int i = 0; i < 60 && master_valid === 1'b1; i++) begin
      vc++;
      if (kb == stall_k && left > 0) begin
        if (left == stall_n) held = {tx_address, tx_data, tx_burst};
        else if ({tx_address, tx_data, tx_burst} !== held) hold_ok = 1'b0;
        slave_ready = 1'b0;
        left--;
      end else begin
        if (kb < 13) begin
          ab[kb] = tx_address; db[kb] = tx_data; bb[kb] = tx_burst;
        end
        slave_ready = 1'b1;
        kb++;
      end
      @(negedge clk);
    end
    slave_ready = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      slave_valid = 1'b1;
      rx_data = b[i];
      @(negedge clk);
    end
    slave_valid = 1'b0;
    rx_data = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++; if (all_out !== 18'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (all_out !== 18'd0) begin fails++; $display("FAIL idle_outputs: got %h want 0", all_out); end
  endtask

  task automatic test_write();
    logic [12:0] ab, db, bb; int vc; logic h;
    do_start(1'b1, 12'hA5C, 8'h3B, 1'b0, 12'd0);
    tests++; if ({busy, write_en, read_en} !== 3'b110) begin fails++; $display("FAIL wr_flags: got %b want 110", {busy, write_en, read_en}); end
    collect_req(-1, 0, ab, db, bb, vc, h);
    tests++; if (vc !== 13) begin fails++; $display("FAIL wr_valid_cycles: got %0d want 13", vc); end
    tests++; if (ab !== 13'h0A5C) begin fails++; $display("FAIL wr_addr_bits: got %h want 0a5c", ab); end
    tests++; if (db !== 13'h003B) begin fails++; $display("FAIL wr_data_bits: got %h want 003b", db); end
    tests++; if (bb !== 13'h0000) begin fails++; $display("FAIL wr_burst_bits: got %h want 0000", bb); end
    tests++; if ({done, busy, write_en} !== 3'b100) begin fails++; $display("FAIL wr_done: got %b want 100", {done, busy, write_en}); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL wr_done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_stall();
    logic [12:0] ab, db, bb; int vc; logic h;
    do_start(1'b1, 12'h123, 8'h5A, 1'b0, 12'd0);
    collect_req(5, 3, ab, db, bb, vc, h);
    tests++; if (vc !== 16) begin fails++; $display("FAIL stall_req_len: got %0d want 16", vc); end
    tests++; if (h !== 1'b1) begin fails++; $display("FAIL stall_hold: got %b want 1", h); end
    tests++; if ({ab, db} !== {13'h0123, 13'h005A}) begin fails++; $display("FAIL stall_bits: got %h/%h want 0123/005a", ab, db); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    logic [12:0] ab, db, bb; int vc; logic h; int rv0, d0;
    rv0 = rv_cnt; d0 = done_cnt;
    do_start(1'b0, 12'h010, 8'hFF, 1'b0, 12'd0);
    collect_req(-1, 0, ab, db, bb, vc, h);
    tests++; if ({ab, db, bb} !== {13'h0010, 13'h0, 13'h0}) begin fails++; $display("FAIL rd_req_bits: got %h/%h/%h want 0010/0000/0000", ab, db, bb); end
    tests++; if ({master_ready, read_en, write_en, done} !== 4'b1100) begin fails++; $display("FAIL rd_rwait: got %b want 1100", {master_ready, read_en, write_en, done}); end
    send_byte(8'hC4);
    tests++; if ({done, rdata_valid, rdata} !== {2'b11, 8'hC4}) begin fails++; $display("FAIL rd_byte: got %b%b %h want 11 c4", done, rdata_valid, rdata); end
    @(negedge clk);
    tests++; if ({done, rdata_valid, busy, master_ready} !== 4'b0000) begin fails++; $display("FAIL rd_after: got %b want 0000", {done, rdata_valid, busy, master_ready}); end
    tests++; if ((rv_cnt - rv0) !== 1 || (done_cnt - d0) !== 1) begin fails++; $display("FAIL rd_pulses: got %0d/%0d want 1/1", rv_cnt - rv0, done_cnt - d0); end
  endtask

  task automatic test_split_read();
    logic [12:0] ab, db, bb; int vc; logic h;
    do_start(1'b0, 12'h2F0, 8'h00, 1'b0, 12'd0);
    collect_req(-1, 0, ab, db, bb, vc, h);
    split_en = 1'b1;
    @(negedge clk);
    tests++; if ({master_ready, busy, read_en} !== 3'b011) begin fails++; $display("FAIL split_enter: got %b want 011", {master_ready, busy, read_en}); end
    split_en = 1'b0;
    start = 1'b1; rw = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if ({master_ready, busy} !== 2'b01) begin fails++; $display("FAIL split_wait: got %b want 01", {master_ready, busy}); end
    send_byte(8'h7E);
    tests++; if ({done, rdata} !== {1'b1, 8'h7E}) begin fails++; $display("FAIL split_byte: got %b %h want 1 7e", done, rdata); end
    @(negedge clk);
    tests++; if ({master_valid, busy} !== 2'b00) begin fails++; $display("FAIL split_start_ignored: got %b want 00", {master_valid, busy}); end
  endtask

  task automatic test_burst_read();
    logic [12:0] ab, db, bb; int vc; logic h; int rv0;
    rv0 = rv_cnt;
    do_start(1'b0, 12'h3C1, 8'h00, 1'b1, 12'd3);
    split_en = 1'b1;
    collect_req(-1, 0, ab, db, bb, vc, h);
    split_en = 1'b0;
    tests++; if (bb !== 13'h0007) begin fails++; $display("FAIL burst_word: got %h want 0007", bb); end
    send_byte(8'h01);
    tests++; if ({done, busy, master_ready, rdata_valid, rdata} !== {4'b0111, 8'h01}) begin fails++; $display("FAIL burst_beat1: got %b %h want 0111 01", {done, busy, master_ready, rdata_valid}, rdata); end
    split_en = 1'b1;
    @(negedge clk);
    tests++; if ({master_ready, rdata_valid, busy} !== 3'b101) begin fails++; $display("FAIL burst_split_ignored: got %b want 101", {master_ready, rdata_valid, busy}); end
    split_en = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    tests++; if ({done, rdata} !== {1'b1, 8'h03}) begin fails++; $display("FAIL burst_done: got %b %h want 1 03", done, rdata); end
    @(negedge clk);
    tests++; if ((rv_cnt - rv0) !== 3) begin fails++; $display("FAIL burst_pulses: got %0d want 3", rv_cnt - rv0); end
    else begin
      tests++; if ({rv_q[rv0], rv_q[rv0+1], rv_q[rv0+2]} !== 24'h010203) begin fails++; $display("FAIL burst_order: got %h %h %h want 01 02 03", rv_q[rv0], rv_q[rv0+1], rv_q[rv0+2]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] ab, db, bb; int vc; logic h; int d0;
    logic [7:0] pat;
    pat = 8'h96;
    d0 = done_cnt;
    do_start(1'b0, 12'h0AA, 8'h00, 1'b0, 12'd0);
    collect_req(-1, 0, ab, db, bb, vc, h);
    for (int i = 0; i < 4; i++) begin
      slave_valid = 1'b1; rx_data = pat[i];
      @(negedge clk);
    end
    tests++; if ({busy, master_ready} !== 2'b11) begin fails++; $display("FAIL mid_rx: got %b want 11", {busy, master_ready}); end
    #1 reset = 1'b1;
    slave_valid = 1'b0; rx_data = 1'b0;
    #1;
    tests++; if (all_out !== 18'd0) begin fails++; $display("FAIL mid_reset_outputs: got %h want 0", all_out); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (done_cnt !== d0) begin fails++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); end
    do_start(1'b0, 12'h5A5, 8'h00, 1'b0, 12'd0);
    collect_req(-1, 0, ab, db, bb, vc, h);
    tests++; if ({vc, ab} !== {32'd13, 13'h05A5}) begin fails++; $display("FAIL mid_restart_req: got %0d %h want 13 05a5", vc, ab); end
    send_byte(8'h3C);
    tests++; if ({done, rdata} !== {1'b1, 8'h3C}) begin fails++; $display("FAIL mid_restart_byte: got %b %h want 1 3c", done, rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_stall();
    test_single_read();
    test_split_read();
    test_burst_read();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge clk.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle transfer request, sampled only in IDLE.
REQ-004 rw  input  1  1 = write, 0 = read; latched with start.
REQ-005 addr_in  input  12  target address; latched with start.
REQ-006 wdata_in  input  8  write byte; latched with start.
REQ-007 burst_in  input  1  1 = burst read; latched with start; ignored for writes.
REQ-008 burst_len_in  input  12  burst beat count; latched with start.
REQ-009 slave_ready  input  1  slave can accept serial request bits.
REQ-010 slave_valid  input  1  slave is driving valid read bits on rx_data.
REQ-011 split_en  input  1  slave has split the read; response follows later.
REQ-012 rx_data  input  1  serial read data from slave, LSB first.
REQ-013 master_valid  output  1  request bits on tx_* are valid.
REQ-014 master_ready  output  1  master accepts read bits.
REQ-015 read_en / write_en  output  1 each  transfer type, held from REQ through the last beat.
REQ-016 tx_address / tx_data / tx_burst  output  1 each  serial address, write data and burst word, LSB first.
REQ-017 rdata  output  8  last received read byte.
REQ-018 rdata_valid  output  1  one-cycle strobe per received byte.
REQ-019 busy / done  output  1 each  transfer in progress / one-cycle completion strobe.

Function
REQ-020 States: IDLE, REQ, RWAIT, SPLIT, RX, DONE.
REQ-021 IDLE: start=1 latches all inputs, sets busy=1 and goes to REQ; burst word = {burst_len_in, burst_in & ~rw}, 13 bits.
REQ-022 REQ: master_valid=1; bit index k (0..12) drives tx_address=addr[k] (0 for k>=12), tx_data=wdata[k] (k<8 and write, else 0), tx_burst=burst_word[k].
REQ-023 k advances only on cycles with master_valid=1 and slave_ready=1; when slave_ready=0, all tx_* hold their value (stall, no timeout).
REQ-024 After bit 12 is accepted: write goes to DONE; read goes to RWAIT; master_valid drops to 0 the next cycle.
REQ-025 RWAIT: master_ready=1; split_en=1 goes to SPLIT; slave_valid=1 goes to RX with the current rx_data captured as bit 0.
REQ-026 SPLIT: master_ready=0, busy stays 1; slave_valid=1 goes to RX with the current bit captured as bit 0 and master_ready=1.
REQ-027 RX: each cycle with slave_valid=1 and master_ready=1 shifts rx_data into bit j (LSB first); cycles with slave_valid=0 stall j.
REQ-028 After 8 bits: rdata updates and rdata_valid pulses in the following cycle; beat counter increments; j wraps to 0.
REQ-029 Beat target N = burst_len (0 treated as 1) when burst is set, else 1; beat counter is 12 bits; reaching N goes to DONE, otherwise stays in RX.
REQ-030 DONE: done=1 for exactly one cycle; busy, read_en, write_en, master_ready clear; next state IDLE.
REQ-031 start outside IDLE is ignored, with no queuing.
REQ-032 split_en seen in RX or REQ is ignored.

Reset
REQ-033 On reset, the block enters IDLE asynchronously.
REQ-034 On reset, all outputs go to 0 and the k, j and beat counters and latched registers clear.
REQ-035 A reset mid-transfer abandons the transfer with no done pulse.

Verification
REQ-036 Write: addr=0xA5C, wdata=0x3B, slave_ready=1 -> tx_address bits 0,0,1,1,1,0,1,0,0,1,0,1 over 13 valid cycles, tx_data=0x3B LSB first, tx_burst=0; done 1 cycle later.
REQ-037 Stall: slave_ready=0 for 3 cycles at k=5 -> tx_* hold bit 5 for 3 cycles; total REQ length 16 cycles.
REQ-038 Single read: addr=0x010, slave returns 0xC4 -> rdata=0xC4, one rdata_valid pulse, done; tx_burst word = 0.
REQ-039 Split read: split_en in RWAIT, slave_valid 6 cycles later with 0x7E -> master_ready=0 during SPLIT, rdata=0x7E, done.
REQ-040 Burst read: burst_len=3, bytes 0x01, 0x02, 0x03 -> three rdata_valid pulses in order, then done; burst word 0x007 sent.
REQ-041 Reset at RX bit 4 -> all outputs 0 immediately, no done; a new start afterwards completes normally.
